// File: rtl/priority_queue_port_ctrl.sv
// priority_queue_port_ctrl
// Front-end and drain controller for the priority queue's single shared
// command port. Upstream writes and local pop requests are merged into one
// legal command stream (at most one command, then at least one quiet cycle).
// The single outstanding pop is tracked, and the returned element is buffered
// in a small output FIFO that downstream drains with a valid/ready handshake.
//
// Ports:
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   wr_valid/wr_data     upstream element offered
//   wr_ready             element accepted this cycle
//   rd_en                pops permitted when high
//   q_write/q_valid/q_data  command to the queue (i_write/i_valid/i_data)
//   q_full/q_empty       queue status flags
//   q_rvalid/q_rdata     queue pop response
//   out_valid/out_data/out_ready  output FIFO stream
//   rd_timeout           sticky flag: a pop response never arrived
//   buf_count            output FIFO occupancy
module priority_queue_port_ctrl #(
  parameter int DATA_LENGTH = 32,
  parameter int BUF_DEPTH   = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           wr_valid,
  input  logic [DATA_LENGTH-1:0]         wr_data,
  output logic                           wr_ready,
  input  logic                           rd_en,
  output logic                           q_write,
  output logic                           q_valid,
  output logic [DATA_LENGTH-1:0]         q_data,
  input  logic                           q_full,
  input  logic                           q_empty,
  input  logic                           q_rvalid,
  input  logic [DATA_LENGTH-1:0]         q_rdata,
  output logic                           out_valid,
  output logic [DATA_LENGTH-1:0]         out_data,
  input  logic                           out_ready,
  output logic                           rd_timeout,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   lastGrantWr_q, lastGrantWr_d;
  logic [TW-1:0]          timeoutCnt_q, timeoutCnt_d;
  logic                   timeout_q, timeout_d;

  logic [DATA_LENGTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]          rdPtr_q, wrPtr_q;
  logic [CW-1:0]          count_q;

  logic                   candWr, candRd, grantWr, grantRd;
  logic                   push, pop;

  // Candidate requests. The read candidate reserves a FIFO slot before the
  // pop is issued, so the eventual response can never overflow the buffer.
  assign candWr  = wr_valid & ~q_full;
  assign candRd  = rd_en & ~q_empty & (count_q < CW'(BUF_DEPTH));
  // Under contention the grant alternates: whichever kind did not win last.
  assign grantWr = candWr & (~candRd | ~lastGrantWr_q);
  assign grantRd = candRd & ~grantWr;

  // Next-state and command decode. Commands are only driven from IDLE and
  // are suppressed while RST is high so the port is quiet during reset.
  always_comb begin
    state_d       = state_q;
    lastGrantWr_d = lastGrantWr_q;
    timeoutCnt_d  = timeoutCnt_q;
    timeout_d     = timeout_q;
    push          = 1'b0;
    q_valid       = 1'b0;
    q_write       = 1'b0;
    q_data        = '0;
    wr_ready      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RST && grantWr) begin
          q_valid       = 1'b1;
          q_write       = 1'b1;
          q_data        = wr_data;
          wr_ready      = 1'b1;
          lastGrantWr_d = 1'b1;
          state_d       = SETTLE;
        end else if (!RST && grantRd) begin
          q_valid       = 1'b1;
          lastGrantWr_d = 1'b0;
          timeoutCnt_d  = '0;
          state_d       = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // A response in the expiry cycle still wins over the timeout.
        if (q_rvalid) begin
          push    = 1'b1;
          state_d = SETTLE;
        end else if (timeoutCnt_q == TW'(TIMEOUT - 2)) begin
          timeout_d = 1'b1;
          state_d   = SETTLE;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TW'(1);
        end
      end
      SETTLE: begin
        // One quiet cycle lets the queue flags reflect the last command.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      lastGrantWr_q <= 1'b0;
      timeoutCnt_q  <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lastGrantWr_q <= lastGrantWr_d;
      timeoutCnt_q  <= timeoutCnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign pop        = out_valid & out_ready;
  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rdPtr_q];
  assign buf_count  = count_q;
  assign rd_timeout = timeout_q;

  // Output FIFO pointers and occupancy; pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wrPtr_q] <= q_rdata;
  end

endmodule

// File: tb/tb_priority_queue_port_ctrl.sv
// Testbench for priority_queue_port_ctrl. A behavioural priority-queue stub
// (max-first, configurable response latency) drives the queue side; each
// test task applies stimulus and compares observations inline.
module tb_priority_queue_port_ctrl;

  localparam int DL   = 32;
  localparam int BD   = 4;
  localparam int TO   = 16;
  localparam int QCAP = 8;

  logic          CLK, RST;
  logic          wr_valid, wr_ready, rd_en;
  logic [DL-1:0] wr_data;
  logic          q_write, q_valid, q_full, q_empty, q_rvalid;
  logic [DL-1:0] q_data, q_rdata;
  logic          out_valid, out_ready, rd_timeout;
  logic [DL-1:0] out_data;
  logic [2:0]    buf_count;

  priority_queue_port_ctrl #(.DATA_LENGTH(DL), .BUF_DEPTH(BD), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en),
    .q_write(q_write), .q_valid(q_valid), .q_data(q_data),
    .q_full(q_full), .q_empty(q_empty), .q_rvalid(q_rvalid), .q_rdata(q_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .rd_timeout(rd_timeout), .buf_count(buf_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus requested for the next cycle.
  logic          tRst, tWrValid, tRdEn, tOutReady;
  logic [DL-1:0] tWrData;

  // Queue stub state.
  logic [DL-1:0] stubMem[$];
  int            stubLat = 1;
  bit            stubSilent = 0;
  bit            forceFull = 0;
  bit            forceRvalid = 0;
  logic [DL-1:0] forceRdata = '0;
  int            respCnt = 0;
  logic [DL-1:0] respData = '0;

  // Expected FIFO contents: responses in delivery order.
  logic [DL-1:0] expOut[$];

  // Observations of the most recent cycle.
  logic          obsQValid, obsQWrite, obsWrReady, obsOutValid, obsTimeout;
  logic          obsQFull, obsQEmpty, obsResp;
  logic [DL-1:0] obsQData, obsOutData;
  logic [2:0]    obsBufCount;

  // One clock cycle: drive inputs after the falling edge, sample #1 later,
  // then let the stub react to any command seen in this cycle.
  task automatic step_cycle();
    int mi;
    @(negedge CLK);
    cyc++;
    RST       = tRst;
    wr_valid  = tWrValid;
    wr_data   = tWrData;
    rd_en     = tRdEn;
    out_ready = tOutReady;
    q_full    = forceFull || (stubMem.size() >= QCAP);
    q_empty   = (stubMem.size() == 0);
    q_rvalid  = 1'b0;
    q_rdata   = '0;
    obsResp   = 1'b0;
    if (respCnt > 0) begin
      respCnt--;
      if (respCnt == 0) begin
        q_rvalid = 1'b1;
        q_rdata  = respData;
        obsResp  = 1'b1;
        expOut.push_back(respData);
      end
    end
    if (forceRvalid) begin
      q_rvalid = 1'b1;
      q_rdata  = forceRdata;
    end
    #1;
    obsQValid   = q_valid;
    obsQWrite   = q_write;
    obsQData    = q_data;
    obsWrReady  = wr_ready;
    obsOutValid = out_valid;
    obsOutData  = out_data;
    obsBufCount = buf_count;
    obsTimeout  = rd_timeout;
    obsQFull    = q_full;
    obsQEmpty   = q_empty;
    if (q_valid === 1'b1 && q_write === 1'b1) begin
      stubMem.push_back(q_data);
    end else if (q_valid === 1'b1 && q_write === 1'b0) begin
      respData = '0;
      if (stubMem.size() > 0) begin
        mi = 0;
        for (int i = 1; i < stubMem.size(); i++)
          if (stubMem[i] > stubMem[mi]) mi = i;
        respData = stubMem[mi];
        stubMem.delete(mi);
      end
      if (!stubSilent) respCnt = stubLat;
    end
  endtask

  task automatic do_reset();
    tRst = 1'b1; tWrValid = 1'b0; tWrData = '0; tRdEn = 1'b0; tOutReady = 1'b0;
    forceFull = 0; forceRvalid = 0; stubSilent = 0; respCnt = 0; stubLat = 1;
    step_cycle();
    step_cycle();
    tRst = 1'b0;
    stubMem.delete();
    expOut.delete();
  endtask

  task automatic test_reset();
    do_reset();
    step_cycle();
    checks++; if (obsQValid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got=%b want=0", obsQValid); end
    checks++; if (obsWrReady !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b want=0", obsWrReady); end
    checks++; if (obsQData !== '0) begin errors++; $display("FAIL reset_q_data got=%0h want=0", obsQData); end
    checks++; if (obsOutValid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", obsOutValid); end
    checks++; if (obsBufCount !== 3'd0) begin errors++; $display("FAIL reset_buf_count got=%0d want=0", obsBufCount); end
    checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL reset_rd_timeout got=%b want=0", obsTimeout); end
  endtask

  task automatic test_writes();
    logic [DL-1:0] vals [3];
    int idx, lastCyc;
    vals = '{32'd5, 32'd9, 32'd2};
    idx = 0; lastCyc = -1;
    tRdEn = 1'b0; tOutReady = 1'b0;
    for (int n = 0; n < 20 && idx < 3; n++) begin
      tWrValid = 1'b1; tWrData = vals[idx];
      step_cycle();
      if (obsQValid === 1'b1) begin
        checks++; if (obsQWrite !== 1'b1) begin errors++; $display("FAIL write_q_write got=%b want=1", obsQWrite); end
        checks++; if (obsQData !== vals[idx]) begin errors++; $display("FAIL write_q_data got=%0d want=%0d", obsQData, vals[idx]); end
        checks++; if (obsWrReady !== 1'b1) begin errors++; $display("FAIL write_wr_ready got=%b want=1", obsWrReady); end
        if (lastCyc >= 0) begin
          checks++; if (cyc - lastCyc != 2) begin errors++; $display("FAIL write_spacing got=%0d want=2", cyc - lastCyc); end
        end
        lastCyc = cyc;
        idx++;
      end else begin
        checks++; if (obsWrReady !== 1'b0) begin errors++; $display("FAIL write_idle_ready got=%b want=0", obsWrReady); end
        checks++; if (obsQData !== '0) begin errors++; $display("FAIL write_idle_data got=%0h want=0", obsQData); end
      end
      checks++; if (obsOutValid !== 1'b0) begin errors++; $display("FAIL write_out_valid got=%b want=0", obsOutValid); end
    end
    tWrValid = 1'b0;
    checks++; if (idx != 3) begin errors++; $display("FAIL write_count got=%0d want=3", idx); end
  endtask

  task automatic test_drain();
    logic [DL-1:0] want [3];
    int k;
    want = '{32'd9, 32'd5, 32'd2};
    k = 0;
    tRdEn = 1'b1; tOutReady = 1'b1; tWrValid = 1'b0; stubLat = 1;
    for (int n = 0; n < 60 && k < 3; n++) begin
      step_cycle();
      if (obsOutValid === 1'b1) begin
        checks++; if (obsOutData !== want[k]) begin errors++; $display("FAIL drain_data got=%0d want=%0d", obsOutData, want[k]); end
        k++;
        if (expOut.size() > 0) void'(expOut.pop_front());
      end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL drain_count got=%0d want=3", k); end
    for (int n = 0; n < 10; n++) begin
      step_cycle();
      checks++; if (obsQValid !== 1'b0) begin errors++; $display("FAIL drain_empty_cmd got=%b want=0", obsQValid); end
    end
    checks++; if (obsBufCount !== 3'd0) begin errors++; $display("FAIL drain_buf_count got=%0d want=0", obsBufCount); end
  endtask

  task automatic test_contention();
    int g;
    logic prevValid;
    g = 0; prevValid = 1'b0;
    stubMem.push_back(32'd100); stubMem.push_back(32'd200); stubMem.push_back(32'd300);
    tRdEn = 1'b1; tOutReady = 1'b1; stubLat = 1;
    for (int n = 0; n < 80 && g < 6; n++) begin
      tWrValid = 1'b1; tWrData = $urandom;
      step_cycle();
      checks++; if (prevValid === 1'b1 && obsQValid === 1'b1) begin errors++; $display("FAIL contention_gap got=back-to-back want=gap"); end
      if (obsQValid === 1'b1) begin
        checks++; if (obsQWrite !== ((g % 2) == 0)) begin errors++; $display("FAIL contention_order grant=%0d got_write=%b", g, obsQWrite); end
        if (obsQWrite === 1'b1) begin
          checks++; if (obsQData !== tWrData) begin errors++; $display("FAIL contention_wdata got=%0h want=%0h", obsQData, tWrData); end
        end
        g++;
      end
      if (obsOutValid === 1'b1) begin
        checks++; if (expOut.size() == 0 || obsOutData !== expOut[0]) begin errors++; $display("FAIL contention_out got=%0h want=%0h", obsOutData, (expOut.size() > 0) ? expOut[0] : '0); end
        if (expOut.size() > 0) void'(expOut.pop_front());
      end
      prevValid = obsQValid;
    end
    tWrValid = 1'b0;
    checks++; if (g != 6) begin errors++; $display("FAIL contention_grants got=%0d want=6", g); end
  endtask

  task automatic test_backpressure();
    int reads;
    do_reset();
    stubMem = '{32'd10, 32'd60, 32'd30, 32'd50, 32'd20, 32'd40};
    tRdEn = 1'b1; tOutReady = 1'b0; stubLat = 1; reads = 0;
    for (int n = 0; n < 40; n++) begin
      step_cycle();
      if (obsQValid === 1'b1 && obsQWrite === 1'b0) reads++;
    end
    checks++; if (reads != 4) begin errors++; $display("FAIL bp_reads got=%0d want=4", reads); end
    checks++; if (obsBufCount !== 3'd4) begin errors++; $display("FAIL bp_buf_count got=%0d want=4", obsBufCount); end
    checks++; if (obsOutValid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b want=1", obsOutValid); end
    checks++; if (obsOutData !== 32'd60) begin errors++; $display("FAIL bp_head got=%0d want=60", obsOutData); end
    tOutReady = 1'b1;
    step_cycle();
    tOutReady = 1'b0;
    reads = 0;
    for (int n = 0; n < 30; n++) begin
      step_cycle();
      if (obsQValid === 1'b1 && obsQWrite === 1'b0) reads++;
    end
    checks++; if (reads != 1) begin errors++; $display("FAIL bp_extra_reads got=%0d want=1", reads); end
    checks++; if (obsBufCount !== 3'd4) begin errors++; $display("FAIL bp_refill got=%0d want=4", obsBufCount); end
    checks++; if (obsOutData !== 32'd50) begin errors++; $display("FAIL bp_next_head got=%0d want=50", obsOutData); end
  endtask

  task automatic test_timeout();
    int strobe;
    bit got;
    do_reset();
    stubMem.push_back(32'd7);
    stubSilent = 1; tRdEn = 1'b1; tOutReady = 1'b1; strobe = -1;
    for (int n = 0; n < 10 && strobe < 0; n++) begin
      step_cycle();
      if (obsQValid === 1'b1 && obsQWrite === 1'b0) strobe = cyc;
    end
    checks++; if (strobe < 0) begin errors++; $display("FAIL timeout_strobe got=none want=read"); end
    for (int d = 1; d <= TO + 3; d++) begin
      forceRvalid = (d == TO || d == TO + 1);
      forceRdata  = 32'hDEAD;
      step_cycle();
      forceRvalid = 0;
      checks++; if (obsTimeout !== (d >= TO)) begin errors++; $display("FAIL timeout_flag d=%0d got=%b want=%b", d, obsTimeout, d >= TO); end
      checks++; if (obsBufCount !== 3'd0) begin errors++; $display("FAIL timeout_late_push got=%0d want=0", obsBufCount); end
    end
    tWrValid = 1'b1; tWrData = 32'h33; got = 0;
    for (int n = 0; n < 6 && !got; n++) begin
      step_cycle();
      if (obsQValid === 1'b1 && obsQWrite === 1'b1) begin
        got = 1;
        checks++; if (obsQData !== 32'h33) begin errors++; $display("FAIL timeout_write_data got=%0h want=33", obsQData); end
      end
    end
    tWrValid = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL timeout_write got=none want=write"); end
    checks++; if (obsTimeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b want=1", obsTimeout); end
    stubSilent = 0;
  endtask

  task automatic test_full_and_reset();
    bit strobe;
    do_reset();
    forceFull = 1; tWrValid = 1'b1; tWrData = 32'h44; tRdEn = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step_cycle();
      checks++; if (obsWrReady !== 1'b0) begin errors++; $display("FAIL full_wr_ready got=%b want=0", obsWrReady); end
      checks++; if (obsQValid !== 1'b0) begin errors++; $display("FAIL full_q_valid got=%b want=0", obsQValid); end
    end
    forceFull = 0; tWrValid = 1'b0; stubMem.push_back(32'h77); stubLat = 4; tRdEn = 1'b1; strobe = 0;
    for (int n = 0; n < 10 && !strobe; n++) begin
      step_cycle();
      if (obsQValid === 1'b1 && obsQWrite === 1'b0) strobe = 1;
    end
    checks++; if (!strobe) begin errors++; $display("FAIL rst_read_strobe got=none want=read"); end
    step_cycle();
    tRst = 1'b1; tWrValid = 1'b1;
    step_cycle();
    checks++; if (obsQValid !== 1'b0) begin errors++; $display("FAIL rst_q_valid got=%b want=0", obsQValid); end
    checks++; if (obsWrReady !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got=%b want=0", obsWrReady); end
    tRst = 1'b0; tWrValid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step_cycle();
      checks++; if (obsOutValid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", obsOutValid); end
      checks++; if (obsBufCount !== 3'd0) begin errors++; $display("FAIL rst_buf_count got=%0d want=0", obsBufCount); end
      checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b want=0", obsTimeout); end
      checks++; if (obsQValid !== 1'b0 || obsQData !== '0) begin errors++; $display("FAIL rst_cmd got=%b/%0h want=0/0", obsQValid, obsQData); end
    end
    expOut.delete();
    stubLat = 1;
  endtask

  // Randomized traffic against a transaction-level model: the controller is
  // busy for one extra cycle after a write and until one cycle after the
  // response of a read; when free it must grant by the alternation rule.
  task automatic test_random();
    int modelCount, freeAt;
    bit lastW, candW, candR, expValid, expWrite;
    do_reset();
    modelCount = 0; freeAt = cyc + 1; lastW = 0;
    for (int n = 0; n < 1500; n++) begin
      tWrValid  = $urandom_range(0, 1);
      tWrData   = $urandom;
      tRdEn     = ($urandom_range(0, 3) != 0);
      tOutReady = ($urandom_range(0, 2) != 0);
      forceFull = ($urandom_range(0, 9) == 0);
      stubLat   = $urandom_range(1, 3);
      step_cycle();
      candW = tWrValid && !obsQFull;
      candR = tRdEn && !obsQEmpty && (modelCount < BD);
      expValid = (cyc >= freeAt) && (candW || candR);
      expWrite = expValid && candW && (!candR || !lastW);
      checks++; if (obsQValid !== expValid) begin errors++; $display("FAIL rand_q_valid cyc=%0d got=%b want=%b", cyc, obsQValid, expValid); end
      if (expValid) begin
        checks++; if (obsQWrite !== expWrite) begin errors++; $display("FAIL rand_q_write cyc=%0d got=%b want=%b", cyc, obsQWrite, expWrite); end
      end
      checks++; if (obsWrReady !== (obsQValid & obsQWrite)) begin errors++; $display("FAIL rand_wr_ready cyc=%0d got=%b want=%b", cyc, obsWrReady, obsQValid & obsQWrite); end
      checks++; if (obsQData !== ((obsQValid === 1'b1 && obsQWrite === 1'b1) ? tWrData : '0)) begin errors++; $display("FAIL rand_q_data cyc=%0d got=%0h", cyc, obsQData); end
      checks++; if (obsBufCount !== 3'(modelCount)) begin errors++; $display("FAIL rand_buf_count cyc=%0d got=%0d want=%0d", cyc, obsBufCount, modelCount); end
      checks++; if (obsOutValid !== (modelCount != 0)) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b want=%b", cyc, obsOutValid, modelCount != 0); end
      if (modelCount != 0) begin
        checks++; if (obsOutData !== expOut[0]) begin errors++; $display("FAIL rand_out_data cyc=%0d got=%0h want=%0h", cyc, obsOutData, expOut[0]); end
      end
      checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL rand_timeout cyc=%0d got=%b want=0", cyc, obsTimeout); end
      if (obsQValid === 1'b1) begin
        lastW  = obsQWrite;
        freeAt = (obsQWrite === 1'b1) ? cyc + 2 : cyc + stubLat + 2;
      end
      if (modelCount > 0 && tOutReady) begin
        void'(expOut.pop_front());
        modelCount--;
      end
      if (obsResp) modelCount++;
    end
    forceFull = 0;
  endtask

  initial begin
    RST = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; out_ready = 1'b0;
    q_full = 1'b0; q_empty = 1'b1; q_rvalid = 1'b0; q_rdata = '0;
    tRst = 1'b1; tWrValid = 1'b0; tWrData = '0; tRdEn = 1'b0; tOutReady = 1'b0;
    test_reset();
    test_writes();
    test_drain();
    test_contention();
    test_backpressure();
    test_timeout();
    test_full_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
